// File: rtl/rc4_search_pkg.sv
// Shared types and constants for the RC4 brute-force key search controller.
// Holds the controller/checker state encodings, the plaintext character
// window and the byte classifier used when scanning decrypted memory.
package rc4_search_pkg;

  localparam int MSG_LEN_DEF = 32;
  localparam int ADDR_W      = 5;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LO    = 8'h61;
  localparam logic [7:0] CH_HI    = 8'h7A;

  // Key-search controller states (exposed on dbg_state).
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_CORE = 3'd2,
    ST_CHECK     = 3'd3,
    ST_NEXT      = 3'd4,
    ST_FOUND     = 3'd5,
    ST_FAIL      = 3'd6
  } search_state_e;

  // Message checker states (exposed on dbg_chk_state).
  typedef enum logic [1:0] {
    CK_IDLE = 2'd0,
    CK_ADDR = 2'd1,
    CK_WAIT = 2'd2,
    CK_EVAL = 2'd3
  } chk_state_e;

  // A plausible plaintext byte is a lowercase letter or a space.
  function automatic logic is_valid_char(input logic [7:0] b);
    return (b == CH_SPACE) || ((b >= CH_LO) && (b <= CH_HI));
  endfunction

endpackage

// File: rtl/rc4_msg_checker.sv
// Scans decrypted_memory for a plausible plaintext after each pipeline pass.
// Each byte costs three cycles: present address, wait one RAM latency cycle,
// evaluate. The first invalid byte aborts the scan.
// Handshake: chk_go (1 cycle, only accepted in CK_IDLE) starts a scan from
// address 0; exactly one of chk_pass / chk_fail pulses for one cycle in
// CK_EVAL when the scan ends, and the checker is back in CK_IDLE next cycle.
module rc4_msg_checker
  import rc4_search_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chk_go,
  input  logic [7:0]        chk_data,
  output logic [ADDR_W-1:0] chk_addr,
  output logic              chk_pass,
  output logic              chk_fail,
  output logic [1:0]        dbg_chk_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              byte_ok;

  // Next-state, index update and end-of-scan pulses (pulses are decoded
  // from CK_EVAL so the controller reacts in the same cycle as the sample).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chk_pass = 1'b0;
    chk_fail = 1'b0;
    byte_ok  = is_valid_char(chk_data);
    case (state_q)
      CK_IDLE: begin
        if (chk_go) begin
          idx_d   = '0;
          state_d = CK_ADDR;
        end
      end
      CK_ADDR: state_d = CK_WAIT;
      CK_WAIT: state_d = CK_EVAL;
      CK_EVAL: begin
        if (!byte_ok) begin
          chk_fail = 1'b1;
          state_d  = CK_IDLE;
        end else if (idx_q == LAST_IDX) begin
          chk_pass = 1'b1;
          state_d  = CK_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = CK_ADDR;
        end
      end
      default: state_d = CK_IDLE;
    endcase
  end

  // State and index registers; the index doubles as the held RAM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CK_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign chk_addr      = idx_q;
  assign dbg_chk_state = state_q;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force key sequencer sitting above the RC4 Initialize/Shuffle/Decrypt
// FSMs. Walks keys from 0 to KEY_MAX, launches one pipeline pass per key and
// has rc4_msg_checker scan the decrypted message; stops on the first key that
// yields plausible plaintext or after KEY_MAX.
// Optional feature: define RC4_SEARCH_TIMEOUT_EN to add a WAIT_CORE watchdog
// that ends the search with timeout=1 after TIMEOUT_CYC cycles without
// core_done. Without it, WAIT_CORE waits indefinitely and timeout is 0.
module rc4_key_search_ctrl
  import rc4_search_pkg::*;
#(
  parameter int               KEY_W       = 24,
  parameter logic [KEY_W-1:0] KEY_MAX     = 'h3FFFFF,
  parameter int               MSG_LEN     = 32,
  parameter int               TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              core_start,
  input  logic              core_done,
  output logic [KEY_W-1:0]  core_key,
  output logic [ADDR_W-1:0] chk_addr,
  input  logic [7:0]        chk_data,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic [KEY_W-1:0]  key_found,
  output logic              timeout,
  output logic [2:0]        dbg_state,
  output logic [1:0]        dbg_chk_state
);

  search_state_e    state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] key_found_q, key_found_d;
  logic             found_q, found_d;
  logic             exhausted_q, exhausted_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             core_start_q, core_start_d;
  logic             chk_go, chk_pass, chk_fail;

`ifdef RC4_SEARCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT_CYC;
`endif

  rc4_msg_checker #(
    .MSG_LEN(MSG_LEN)
  ) u_checker (
    .clk          (clk),
    .reset_n      (reset_n),
    .chk_go       (chk_go),
    .chk_data     (chk_data),
    .chk_addr     (chk_addr),
    .chk_pass     (chk_pass),
    .chk_fail     (chk_fail),
    .dbg_chk_state(dbg_chk_state)
  );

  // Search sequencing: launch, wait for the core, hand off to the checker,
  // advance the key or finish. core_start and busy are registered from the
  // next state so they line up exactly with LAUNCH / the active states.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_found_d = key_found_q;
    found_d     = found_q;
    exhausted_d = exhausted_q;
    timeout_d   = timeout_q;
    chk_go      = 1'b0;
`ifdef RC4_SEARCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (start) begin
          key_d       = '0;
          key_found_d = '0;
          found_d     = 1'b0;
          exhausted_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
`ifdef RC4_SEARCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (core_done) begin
          chk_go  = 1'b1;
          state_d = ST_CHECK;
        end
`ifdef RC4_SEARCH_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_FAIL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      ST_CHECK: begin
        if (chk_pass) begin
          found_d     = 1'b1;
          key_found_d = key_q;
          state_d     = ST_FOUND;
        end else if (chk_fail) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (key_q == KEY_MAX) begin
          exhausted_d = 1'b1;
          state_d     = ST_FAIL;
        end else begin
          key_d   = key_q + 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    core_start_d = (state_d == ST_LAUNCH);
    busy_d       = !(state_d inside {ST_IDLE, ST_FOUND, ST_FAIL});
  end

  // Controller registers; reset aborts any search without emitting pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      key_found_q  <= '0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_found_q  <= key_found_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
    end
  end

`ifdef RC4_SEARCH_TIMEOUT_EN
  // Watchdog counter: cycles spent in WAIT_CORE since entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  assign core_start = core_start_q;
  assign core_key   = key_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign key_found  = key_found_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with a small core/RAM model.
// The DUT is built with KEY_MAX=3 and TIMEOUT_CYC=100; define
// RC4_SEARCH_TIMEOUT_EN to exercise the watchdog branch.
module tb_rc4_key_search_ctrl;

  localparam int          KEY_W   = 24;
  localparam logic [23:0] KEY_LIM = 24'h3;
  localparam int          TO_CYC  = 100;
  localparam int          LAT     = 6;
  localparam logic [2:0]  TB_ST_CHECK = 3'd3;

  localparam int M_NONE     = 0;
  localparam int M_MATCH3   = 1;
  localparam int M_BOUND    = 2;
  localparam int M_BADLAST  = 3;
  localparam int M_BADFIRST = 4;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             core_start;
  logic             core_done;
  logic [KEY_W-1:0] core_key;
  logic [4:0]       chk_addr;
  logic [7:0]       chk_data;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic [KEY_W-1:0] key_found;
  logic             timeout;
  logic [2:0]       dbg_state;
  logic [1:0]       dbg_chk_state;

  int               mode;
  int               launches;
  logic [23:0]      key_log[$];
  logic [7:0]       mem[32];
  int               max_addr;
  int               check_cycles;
  int               manual_req;
  int               n_assert;
  int               n_fail;
  int               cyc;

  rc4_key_search_ctrl #(
    .KEY_W      (KEY_W),
    .KEY_MAX    (KEY_LIM),
    .MSG_LEN    (32),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .core_start   (core_start),
    .core_done    (core_done),
    .core_key     (core_key),
    .chk_addr     (chk_addr),
    .chk_data     (chk_data),
    .busy         (busy),
    .found        (found),
    .exhausted    (exhausted),
    .key_found    (key_found),
    .timeout      (timeout),
    .dbg_state    (dbg_state),
    .dbg_chk_state(dbg_chk_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // message image the core produces for a given key
  task automatic fill_mem(input logic [23:0] k);
    string s;
    s = "the secret is abc";
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    case (mode)
      M_MATCH3: begin
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
        if (k != 24'd3) mem[5] = 8'h01;
      end
      M_BOUND: begin
        mem[0]  = 8'h20;
        mem[1]  = 8'h61;
        mem[31] = 8'h7A;
      end
      M_BADLAST: begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h61;
        mem[31] = (k == 24'd0) ? 8'h7B : 8'h7A;
      end
      M_BADFIRST: begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h61;
        mem[0] = 8'h60;
      end
      default: ;
    endcase
  endtask

  // core + decrypted_memory model (1-cycle read latency)
  initial begin : core_model
    int         pending;
    int         manual_seen;
    logic [4:0] prev_addr;
    pending     = 0;
    manual_seen = 0;
    prev_addr   = '0;
    core_done   = 1'b0;
    chk_data    = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      chk_data  = mem[prev_addr];
      prev_addr = chk_addr;
      if (dbg_state == TB_ST_CHECK) begin
        check_cycles++;
        if (int'(chk_addr) > max_addr) max_addr = int'(chk_addr);
      end
      core_done = 1'b0;
      if (!reset_n) begin
        pending = 0;
      end else if (core_start) begin
        launches++;
        key_log.push_back(core_key);
        fill_mem(core_key);
        if (mode != M_NONE) pending = LAT;
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) core_done = 1'b1;
      end
      if (manual_req != manual_seen) begin
        manual_seen = manual_req;
        core_done   = 1'b1;
      end
    end
  end

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!(found || exhausted || timeout) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_in_budget", 32'(c < budget), 32'd1);
  endtask

  task automatic clear_log();
    launches     = 0;
    check_cycles = 0;
    max_addr     = 0;
    key_log.delete();
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    manual_req = 0;
    mode       = M_NONE;
    clear_log();
    start   = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_exhausted", 32'(exhausted), 32'd0);
    check("rst_key_found", 32'(key_found), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_chk_addr", 32'(chk_addr), 32'd0);
    check("rst_core_key", 32'(core_key), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    mode = M_MATCH3;
    pulse_start();
    check("launch_core_start", 32'(core_start), 32'd1);
    check("launch_core_key", 32'(core_key), 32'd0);
    check("launch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("core_start_one_cycle", 32'(core_start), 32'd0);

    // 2: match on key 3
    wait_done(2000);
    check("m3_found", 32'(found), 32'd1);
    check("m3_key_found", 32'(key_found), 32'd3);
    check("m3_busy", 32'(busy), 32'd0);
    check("m3_exhausted", 32'(exhausted), 32'd0);
    check("m3_launches", 32'(launches), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("m3_key_seq%0d", i), 32'(key_log[i]), 32'(i));
    repeat (20) @(negedge clk);
    check("m3_no_more_launch", 32'(launches), 32'd4);

    // 3a: boundary characters accepted on key 0
    clear_log();
    mode = M_BOUND;
    pulse_start();
    check("bound_found_cleared", 32'(found), 32'd0);
    check("bound_key_found_cleared", 32'(key_found), 32'd0);
    wait_done(2000);
    check("bound_found", 32'(found), 32'd1);
    check("bound_key_found", 32'(key_found), 32'd0);
    check("bound_launches", 32'(launches), 32'd1);
    check("bound_check_cycles", 32'(check_cycles), 32'd96);

    // 3b: 0x7B at the last address rejects key 0, key 1 accepted
    clear_log();
    mode = M_BADLAST;
    pulse_start();
    wait_done(2000);
    check("badlast_found", 32'(found), 32'd1);
    check("badlast_key_found", 32'(key_found), 32'd1);
    check("badlast_launches", 32'(launches), 32'd2);

    // 3c + 4: 0x60 at address 0 for every key -> single read each, exhaustion
    clear_log();
    mode = M_BADFIRST;
    pulse_start();
    wait_done(2000);
    check("exh_exhausted", 32'(exhausted), 32'd1);
    check("exh_found", 32'(found), 32'd0);
    check("exh_key_found", 32'(key_found), 32'd0);
    check("exh_busy", 32'(busy), 32'd0);
    check("exh_timeout", 32'(timeout), 32'd0);
    check("exh_launches", 32'(launches), 32'd4);
    check("exh_max_addr", 32'(max_addr), 32'd0);
    check("exh_check_cycles", 32'(check_cycles), 32'd12);

    // restart after exhaustion; core never answers from here on
    clear_log();
    mode = M_NONE;
    pulse_start();
    check("restart_exh_cleared", 32'(exhausted), 32'd0);
    check("restart_core_start", 32'(core_start), 32'd1);
    check("restart_core_key", 32'(core_key), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    // 5: start while busy ignored, reset in WAIT_CORE aborts
    repeat (3) @(negedge clk);
    pulse_start();
    repeat (5) @(negedge clk);
    check("busy_start_ignored", 32'(launches), 32'd1);
    check("busy_still", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    manual_req++;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_core_start", 32'(core_start), 32'd0);
    check("abort_core_key", 32'(core_key), 32'd0);
    reset_n = 1'b1;
    manual_req++;
    repeat (10) @(negedge clk);
    check("abort_no_launch", 32'(launches), 32'd1);
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_found", 32'(found), 32'd0);
    check("abort_exhausted", 32'(exhausted), 32'd0);

    // 6: core_done withheld
    clear_log();
    pulse_start();
    check("to_launch", 32'(core_start), 32'd1);
`ifdef RC4_SEARCH_TIMEOUT_EN
    cyc = 0;
    while (!timeout && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("to_latency", 32'(cyc), 32'(TO_CYC + 1));
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_exhausted", 32'(exhausted), 32'd0);
    check("to_found", 32'(found), 32'd0);
`else
    cyc = 0;
    repeat (10000) @(negedge clk);
    check("noto_busy", 32'(busy), 32'd1);
    check("noto_timeout", 32'(timeout), 32'd0);
    check("noto_launches", 32'(launches), 32'd1);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
